// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning decoder: mode encodings, FSM state type
// and a constant-evaluable ceil(log2) helper.
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT     = 2'b00;
    localparam logic [1:0] MODE_SCAN       = 2'b01;
    localparam logic [1:0] MODE_SWEEP      = 2'b10;
    localparam logic [1:0] MODE_DIRECT_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_SWEEP  = 2'd3
    } dec_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (1 << i)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N one-hot decode with selectable output polarity.
// With active low, every line sits at its inactive level.
module onehot_dec #(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [N-1:0]      idx,
    input  logic              active,
    output logic [(1<<N)-1:0] d
);

    logic [(1<<N)-1:0] hot;

    always_comb begin
        hot = '0;
        if (active) hot[idx] = 1'b1;
        d = ACTIVE_LOW ? ~hot : hot;
    end

endmodule

// File: rtl/decoder_scan_nm.sv
// Registered N-to-2^N decoder with direct addressing, free-running scan and a
// single sweep that ends with a one-cycle done pulse.
module decoder_scan_nm
    import decoder_pkg::*;
#(
    parameter int N          = 2,
    parameter int DWELL      = 1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_n,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    input  logic              start,
    output logic [(1<<N)-1:0] d,
    output logic [N-1:0]      idx,
    output logic              busy,
    output logic              done,
    output dec_state_t        state
);

    localparam int CW = (clog2(DWELL) > 1) ? clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST = '1;

    dec_state_t     state_q, state_n;
    logic [N-1:0]   idx_q, idx_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic           active_q, active_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic           is_direct;
    logic           rollover;
    logic           to_idle;

    assign is_direct = (mode == MODE_DIRECT) || (mode == MODE_DIRECT_ALT);
    assign rollover  = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            active_q <= active_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // A mode that no longer matches the running state wins over load, start
    // and dwell rollover; en_n wins over everything.
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        active_n = active_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        to_idle  = 1'b0;

        if (en_n) begin
            to_idle = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_direct && load) begin
                        state_n  = ST_DIRECT;
                        idx_n    = sel;
                        active_n = 1'b1;
                    end else if (mode == MODE_SCAN) begin
                        state_n  = ST_SCAN;
                        idx_n    = '0;
                        cnt_n    = '0;
                        active_n = 1'b1;
                        busy_n   = 1'b1;
                    end else if (mode == MODE_SWEEP && start) begin
                        state_n  = ST_SWEEP;
                        idx_n    = '0;
                        cnt_n    = '0;
                        active_n = 1'b1;
                        busy_n   = 1'b1;
                    end
                end
                ST_DIRECT: begin
                    if (!is_direct) to_idle = 1'b1;
                    else if (load)  idx_n = sel;
                end
                ST_SCAN: begin
                    if (mode != MODE_SCAN) begin
                        to_idle = 1'b1;
                    end else if (rollover) begin
                        cnt_n = '0;
                        idx_n = idx_q + 1'b1;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (mode != MODE_SWEEP) begin
                        to_idle = 1'b1;
                    end else if (rollover) begin
                        cnt_n = '0;
                        if (idx_q == IDX_LAST) begin
                            to_idle = 1'b1;
                            done_n  = 1'b1;
                        end else begin
                            idx_n = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                default: to_idle = 1'b1;
            endcase
        end

        if (to_idle) begin
            state_n  = ST_IDLE;
            idx_n    = '0;
            cnt_n    = '0;
            active_n = 1'b0;
            busy_n   = 1'b0;
        end
    end

    onehot_dec #(
        .N          (N),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .idx    (idx_q),
        .active (active_q),
        .d      (d)
    );

    assign idx   = idx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: doc/decoder_scan_nm.md
# decoder_scan_nm

Parametrised N-to-2^N decoder with registered one-hot output and a built-in scan sequencer. It is the next generation of the gate-level 2-4 decoder. It adds width generalisation, selectable output polarity, registered direct decode, free-running scan and a single-sweep mode with completion pulse. It sits between control logic and row, digit or chip-select lines that are either addressed directly or walked in sequence.

## Interface
- N, 2, select width; outputs are 2^N wide (N ≥ 1).
- DWELL, 1, cycles each output stays asserted in scan/sweep modes (≥ 1).
- ACTIVE_LOW, 1, 1: asserted output = 0 and inactive = 1; 0: inverted.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en_n  input  1  enable, active-low; high forces all outputs inactive.
- mode  input  2  00 direct, 01 continuous scan, 10 single sweep, 11 treated as direct.
- sel  input  N  select value for direct mode.
- load  input  1  direct-mode strobe; captures sel.
- start  input  1  sweep-mode launch strobe.
- d  output  2^N  decoded lines (polarity per ACTIVE_LOW).
- idx  output  N  index currently asserted.
- busy  output  1  high while scan or sweep is running.
- done  output  1  one-cycle pulse at sweep completion.

## Operation
- FSM states: IDLE, DIRECT, SCAN, SWEEP.
- Reset or en_n=1: state goes to IDLE. d is all inactive, idx=0, dwell counter=0, busy=0, done=0.
- IDLE, en_n=0:
  - mode 00/11 with load → DIRECT.
  - mode 01 → SCAN.
  - mode 10 with start → SWEEP.
  - Otherwise stay in IDLE.
- DIRECT:
  - On load, sel is captured into idx, and d asserts only bit idx.
  - Output holds until the next load, a mode change or en_n=1.
  - busy=0.
- SCAN:
  - Starts at idx=0, and d asserts bit idx.
  - After DWELL cycles, idx increments, wrapping from 2^N-1 to 0.
  - busy=1; runs until mode or en_n changes.
- SWEEP:
  - Walks idx from 0 to 2^N-1, with DWELL cycles on each index.
  - After the last dwell: done=1 for one cycle, d returns to all inactive, state goes to IDLE, busy=0.
  - start during a sweep is ignored.
- Mode change in any active state: the FSM goes to IDLE on the next edge, with idx and the dwell counter cleared. The new mode is then entered by its normal condition (SCAN entry needs no strobe).
- Simultaneous events:
  - en_n=1 overrides everything.
  - A mode change overrides load, start and the dwell rollover in the same cycle.
  - load is ignored outside modes 00/11.
- Exactly one bit of d is asserted in DIRECT, SCAN and SWEEP. No bits are asserted in IDLE.
- Dwell counter width: max(1, clog2(DWELL)). It counts 0..DWELL-1 and rolls over at DWELL-1.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Direct latency: d and idx update one cycle after the edge that samples load=1.
- Scan/sweep entry: bit 0 is asserted one cycle after entry is sampled (mode=01, or start=1 with mode=10).
- Each index is asserted for exactly DWELL cycles. A full sweep lasts 2^N·DWELL cycles of assertion.
- done is high in the same cycle d first returns to all inactive.
- en_n rising:
  - Synchronous effect: outputs go inactive on the next edge.
  - rst_n low: outputs go inactive immediately (asynchronous).
- Reset mid-sweep: no done pulse is produced.

## Structure
- Shared package decoder_pkg holds:
  - The mode encodings MODE_DIRECT, MODE_SCAN, MODE_SWEEP.
  - The state typedef dec_state_t.
  - A clog2 helper function.
- One sub-module, onehot_dec: a purely combinational N-to-2^N decode with a polarity parameter, instantiated on the registered idx plus an active flag.
- The top level holds the FSM, the dwell counter and the output register.

## Test plan
- Direct decode, N=3, ACTIVE_LOW=1: reset, en_n=0, mode=00, load with sel=5 → next cycle d=8'b1101_1111, idx=5, busy=0.
- Scan wrap, N=2, DWELL=3, ACTIVE_LOW=0, mode=01 → d cycles 0001, 0010, 0100, 1000, 0001, with 3 cycles each and busy=1 throughout.
- Single sweep, N=2, DWELL=2, start pulse → d asserts 8 cycles across bits 0–3. Then done=1 for 1 cycle with d=0000 and busy=0. A second start mid-sweep has no effect.
- Enable override: en_n=1 mid-scan → next cycle d is all inactive, idx=0. With en_n=0 again, scan restarts at idx=0.
- Mode change mid-sweep (10→00 at idx=2) → IDLE next cycle with no done pulse. A following load with sel=1 → d asserts bit 1.
- Async reset mid-scan: rst_n=0 between edges → d goes inactive and idx=0 immediately, and stays so until rst_n=1.
